// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator result stage.
//   op_e    : operation encoding carried on the op port
//   state_e : control states of calc_result_unit
// -----------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      ADD    = 2'b00,
      SUB    = 2'b01,
      MUL    = 2'b10,
      PASS_A = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      FIX  = 2'b10
   } state_e;

endpackage : calc_pkg

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Unsigned shift-add multiplier. It forms the product of two N-bit magnitudes in
// N iterations, one per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a_mag/b_mag and begin iterating (ignored while running)
//   a_mag      : N-bit unsigned multiplicand
//   b_mag      : N-bit unsigned multiplier
//   done       : high during the last iteration; product is final after that edge
//   product    : 2N-bit unsigned product magnitude
// -----------------------------------------------------------------------------
module seq_multiplier #(
   parameter int N = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N-1:0]     a_mag,
   input  logic [N-1:0]     b_mag,
   output logic             done,
   output logic [2*N-1:0]   product
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic             busy_q,   busy_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [2*N-1:0]   mcand_q,  mcand_d;
   logic [N-1:0]     mplier_q, mplier_d;
   logic [2*N-1:0]   prod_q,   prod_d;

   assign done    = busy_q && (cnt_q == CNT_LAST);
   assign product = prod_q;

   // NOTE: every variable gets a default at the top of always_comb so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      if (start && !busy_q) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = {{N{1'b0}}, a_mag};
         mplier_d = b_mag;
         prod_d   = '0;
      end else if (busy_q) begin
         // One multiplier bit per cycle, LSB first; the multiplicand walks left.
         if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order. These are plain
   // registers rather than a memory array, so all of them are reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end

endmodule : seq_multiplier

// File: rtl/calc_result_unit.sv
// -----------------------------------------------------------------------------
// calc_result_unit
// Registered, handshaked result stage: ADD/SUB/PASS_A in one cycle, signed MUL
// through seq_multiplier in N+1 cycles. Produces overflow, zero and negative flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake for a, b, op
//   a, b                : N-bit two's complement operands
//   op                  : 00 ADD, 01 SUB, 10 MUL, 11 PASS_A
//   out_valid/out_ready : downstream handshake for res and the flags
//   res                 : N-bit truncated result
//   ovf, zero, neg      : signed overflow, res == 0, res sign bit
// -----------------------------------------------------------------------------
module calc_result_unit
   import calc_pkg::*;
#(
   parameter int N = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  logic [1:0]    op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  res,
   output logic          ovf,
   output logic          zero,
   output logic          neg
);

   state_e           state_q, state_d;
   logic             sign_q, sign_d;
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;

   logic             out_free, accept, mul_start, mul_done;
   logic [N-1:0]     a_mag, b_mag, sum, diff;
   logic [2*N-1:0]   prod_mag, prod_s;
   logic             prod_fits;
   logic             load;
   logic [N-1:0]     new_res;
   logic             new_ovf;

   // The output slot is free when empty or being consumed on this edge.
   assign out_free  = !out_valid_q || out_ready;
   assign in_ready  = (state_q == IDLE) && out_free;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op_e'(op) == MUL);

   // Unsigned magnitudes; the most negative value maps to 2^(N-1), which fits
   // because the magnitude is treated as unsigned.
   assign a_mag = a[N-1] ? -a : a;
   assign b_mag = b[N-1] ? -b : b;
   assign sum   = a + b;
   assign diff  = a - b;

   seq_multiplier #(.N(N)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .done    (mul_done),
      .product (prod_mag)
   );

   // Signed product fits in N bits when bits [2N-1:N-1] are all equal.
   assign prod_s    = sign_q ? -prod_mag : prod_mag;
   assign prod_fits = (&prod_s[2*N-1:N-1]) || !(|prod_s[2*N-1:N-1]);

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      load    = 1'b0;
      new_res = '0;
      new_ovf = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (op_e'(op))
                  ADD: begin
                     load    = 1'b1;
                     new_res = sum;
                     new_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
                  end
                  SUB: begin
                     load    = 1'b1;
                     new_res = diff;
                     new_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
                  end
                  PASS_A: begin
                     load    = 1'b1;
                     new_res = a;
                  end
                  MUL: begin
                     sign_d  = a[N-1] ^ b[N-1];
                     state_d = BUSY;
                  end
               endcase
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // Wait here rather than overwrite a result still held downstream.
            if (out_free) begin
               load    = 1'b1;
               new_res = prod_s[N-1:0];
               new_ovf = !prod_fits;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A reload wins over a consume on the same edge, keeping out_valid high.
      out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      res_d       = load ? new_res          : res_q;
      ovf_d       = load ? new_ovf          : ovf_q;
      zero_d      = load ? (new_res == '0)  : zero_q;
      neg_d       = load ? new_res[N-1]     : neg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b1;
         neg_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
      end
   end

   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;

endmodule : calc_result_unit

// File: tb/tb_calc_result_unit.sv
// -----------------------------------------------------------------------------
// tb_calc_result_unit
// Directed bench for calc_result_unit with N = 6. Inputs change and outputs
// are sampled on the falling clock edge; the DUT works on the rising edge.
// -----------------------------------------------------------------------------
module tb_calc_result_unit;
   import calc_pkg::*;

   localparam int N = 6;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic [1:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  res;
   logic          ovf;
   logic          zero;
   logic          neg;

   int checks = 0;
   int errors = 0;

   calc_result_unit #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one operation for one cycle; returns on the falling edge after
   // the accepting rising edge, with in_valid already dropped.
   task automatic issue(input logic [1:0] o, input int av, input int bv);
      logic [31:0] av_bits;
      logic [31:0] bv_bits;
      av_bits  = av;
      bv_bits  = bv;
      in_valid = 1'b1;
      op       = o;
      a        = av_bits[N-1:0];
      b        = bv_bits[N-1:0];
      next_cycle();
      in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [N-1:0] e_res,
                            input logic e_ovf, input logic e_zero, input logic e_neg);
      check({tag, ".valid"}, out_valid, 1'b1);
      check({tag, ".res"},   res,       e_res);
      check({tag, ".ovf"},   ovf,       e_ovf);
      check({tag, ".zero"},  zero,      e_zero);
      check({tag, ".neg"},   neg,       e_neg);
   endtask

   // MUL: in_ready and out_valid stay low for the N BUSY edges and the FIX
   // edge, and the result shows up exactly N+1 edges after acceptance.
   task automatic run_mul(input string tag, input int av, input int bv);
      issue(MUL, av, bv);
      a = 6'h15;   // inputs wander while busy and must be ignored
      b = 6'h2a;
      op = ADD;
      for (int k = 0; k < N + 1; k++) begin
         check({tag, ".busy_ready"}, in_ready,  1'b0);
         check({tag, ".busy_valid"}, out_valid, 1'b0);
         next_cycle();
      end
   endtask

   // Vectors for the back-to-back ADD burst, as signed integers.
   int va [8] = '{1, 31, -32, -16, -20, 10, 15, -1};
   int vb [8] = '{2,  1,  -1,  16, -10, -25, 15, -1};

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic stale;
      int   s;
      logic [31:0] s_bits;
      logic [N-1:0] e_res;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      op        = ADD;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Reset values.
      check("rst.valid", out_valid, 1'b0);
      check("rst.res",   res,       '0);
      check("rst.ovf",   ovf,       1'b0);
      check("rst.zero",  zero,      1'b1);
      check("rst.neg",   neg,       1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.in_ready", in_ready, 1'b1);

      // ADD 20 + 15 = 35 -> wraps to -29.
      issue(ADD, 20, 15);
      check_out("add_ovf", 6'b100011, 1'b1, 1'b0, 1'b1);
      next_cycle();
      check("add_ovf.consumed", out_valid, 1'b0);

      // SUB -32 - 1 = -33 -> wraps to 31.
      issue(SUB, -32, 1);
      check_out("sub_ovf", 6'd31, 1'b1, 1'b0, 1'b0);

      // ADD 7 + (-7) = 0, back to back with the consume above.
      issue(ADD, 7, -7);
      check_out("add_zero", 6'd0, 1'b0, 1'b1, 1'b0);
      next_cycle();

      // MUL 5 * -6 = -30 (6'b100010).
      run_mul("mul_5x-6", 5, -6);
      check_out("mul_5x-6", 6'b100010, 1'b0, 1'b0, 1'b1);
      next_cycle();

      // MUL -32 * -1 = 32, does not fit.
      run_mul("mul_ovf", -32, -1);
      check_out("mul_ovf", 6'b100000, 1'b1, 1'b0, 1'b1);
      next_cycle();

      // Backpressure: hold ADD 3 + 4 while a SUB 9 - 2 waits upstream.
      out_ready = 1'b0;
      issue(ADD, 3, 4);
      in_valid = 1'b1;
      op       = SUB;
      a        = 6'd9;
      b        = 6'd2;
      for (int k = 0; k < 5; k++) begin
         check("bp.hold_res",   res,       6'd7);
         check("bp.hold_valid", out_valid, 1'b1);
         check("bp.hold_ready", in_ready,  1'b0);
         next_cycle();
      end
      out_ready = 1'b1;
      #1;
      check("bp.release_ready", in_ready, 1'b1);
      next_cycle();
      in_valid = 1'b0;
      check_out("bp.sub", 6'd7, 1'b0, 1'b0, 1'b0);
      next_cycle();
      check("bp.drained", out_valid, 1'b0);

      // Reset three edges into MUL 7 * 3; res still holds 7 from before.
      issue(MUL, 7, 3);
      next_cycle();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmul.valid", out_valid, 1'b0);
      check("rstmul.res",   res,       '0);
      check("rstmul.zero",  zero,      1'b1);
      check("rstmul.ovf",   ovf,       1'b0);
      check("rstmul.neg",   neg,       1'b0);
      check("rstmul.ready", in_ready,  1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         stale = stale | out_valid;
      end
      check("rstmul.no_stale", stale,    1'b0);
      check("rstmul.ready2",   in_ready, 1'b1);
      issue(PASS_A, 12, 5);
      check_out("pass_a", 6'd12, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // Eight ADDs back to back, checked against a signed integer model.
      in_valid = 1'b1;
      op       = ADD;
      for (int i = 0; i < 8; i++) begin
         s_bits = va[i];
         a      = s_bits[N-1:0];
         s_bits = vb[i];
         b      = s_bits[N-1:0];
         check("b2b.in_ready", in_ready, 1'b1);
         next_cycle();
         s      = va[i] + vb[i];
         s_bits = s;
         e_res  = s_bits[N-1:0];
         check_out($sformatf("b2b[%0d]", i), e_res,
                   (s > 31) || (s < -32), e_res == '0, e_res[N-1]);
      end
      in_valid = 1'b0;
      next_cycle();
      check("b2b.drained", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_calc_result_unit
